// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder and its word array.
// The optional alignment/range fault check is enabled by DMEM_ALIGN_CHECK_EN.
package dmem_responder_pkg;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_LATENCY    = 2;
    localparam int CNT_WIDTH      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic RESP_OK    = 1'b0;
    localparam logic RESP_FAULT = 1'b1;

    function automatic logic [CNT_WIDTH-1:0] wait_init(input int lat);
        return (lat > 0) ? CNT_WIDTH'(lat - 1) : '0;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data array: byte-enable write port, registered read port.
// Stores and no-op accesses load zero into the read register.
module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  we,
    input  logic [3:0]            be,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
                rdata <= '0;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, programmable wait, held response.
// Define DMEM_ALIGN_CHECK_EN to fault misaligned or out-of-range addresses.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam logic [CNT_WIDTH-1:0] CNT_INIT = wait_init(LATENCY);
    localparam bit ZERO_LAT = (LATENCY == 0);

    state_t                state;
    logic [CNT_WIDTH-1:0]  cnt;

    logic                  r_write;
    logic                  r_fault;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [31:0]           r_wdata;
    logic [3:0]            r_be;

    logic                  in_fault;
    logic                  use_in;
    logic                  access;
    logic                  a_write;
    logic                  a_fault;
    logic [ADDR_WIDTH-1:0] a_idx;
    logic [31:0]           a_wdata;
    logic [3:0]            a_be;

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);

    // Zero latency accesses straight from the request bus on the accept edge.
    assign use_in = (state == IDLE);
    assign access = ZERO_LAT ? (use_in && req_valid)
                             : (state == WAIT && cnt == '0);

    assign a_write = use_in ? req_write                   : r_write;
    assign a_fault = use_in ? in_fault                    : r_fault;
    assign a_idx   = use_in ? req_addr[ADDR_WIDTH+1:2]    : r_idx;
    assign a_wdata = use_in ? req_wdata                   : r_wdata;
    assign a_be    = use_in ? req_be                      : r_be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            r_write <= 1'b0;
            r_fault <= 1'b0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_write <= req_write;
                        r_fault <= in_fault;
                        r_idx   <= req_addr[ADDR_WIDTH+1:2];
                        r_wdata <= req_wdata;
                        r_be    <= req_be;
                        cnt     <= CNT_INIT;
                        if (ZERO_LAT) state <= RESP;
                        else          state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) state <= RESP;
                    else           cnt   <= cnt - CNT_WIDTH'(1);
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A faulting access becomes an empty store: nothing written, zero read back.
    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .en   (access),
        .we   (a_write | a_fault),
        .be   (a_fault ? 4'b0000 : a_be),
        .addr (a_idx),
        .wdata(a_wdata),
        .rdata(resp_rdata)
    );

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_q;

    assign in_fault = (req_addr[1:0] != 2'b00) ||
                      (|req_addr[31:ADDR_WIDTH+2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= RESP_OK;
        end else if (access) begin
            err_q <= a_fault ? RESP_FAULT : RESP_OK;
        end else if (state == RESP && resp_ready) begin
            err_q <= RESP_OK;
        end
    end

    assign resp_err = err_q;
`else
    logic unused_addr;

    assign in_fault    = 1'b0;
    assign resp_err    = RESP_OK;
    assign unused_addr = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed cases, random traffic,
// reset during WAIT, and a zero-latency instance.
`timescale 1ns/1ps
module tb_dmem_responder;

    localparam int AW  = 10;
    localparam int LAT = 2;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr  = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be    = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic        z_req_valid = 1'b0;
    logic        z_req_ready;
    logic        z_req_write = 1'b0;
    logic [31:0] z_req_addr  = '0;
    logic [31:0] z_req_wdata = '0;
    logic [3:0]  z_req_be    = '0;
    logic        z_resp_valid;
    logic        z_resp_ready = 1'b0;
    logic [31:0] z_resp_rdata;
    logic        z_resp_err;

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_be(req_be),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_responder #(.ADDR_WIDTH(AW), .LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_write(z_req_write), .req_addr(z_req_addr),
        .req_wdata(z_req_wdata), .req_be(z_req_be),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          t;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model [1 << AW];
    bit          rr_rand = 1'b0;
    int          last_hs = -1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] a);
        return ALIGN && ((a[1:0] != 2'b00) || (a[31:AW+2] != '0));
    endfunction

    task automatic model_clear();
        for (int i = 0; i < (1 << AW); i++) model[i] = '0;
    endtask

    // Drives one request, waits for acceptance, predicts its response.
    task automatic do_req(input bit w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be,
                          output int t);
        exp_t e;
        int   idx;
        int   n;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_be    = be;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 200);
        if (!req_ready) begin
            errors++;
            $display("FAIL req_accept_timeout: addr 0x%08h not accepted", a);
            req_valid = 1'b0;
            t = -1;
            return;
        end
        t     = cyc;
        idx   = int'(a[AW+1:2]);
        e.t   = cyc;
        e.err = is_fault(a);
        if (w) begin
            e.rdata = '0;
            if (!e.err) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) model[idx][8*b +: 8] = d[8*b +: 8];
                end
            end
        end else begin
            e.rdata = e.err ? 32'h0 : model[idx];
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom);
        req_write = 1'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((q.size() != 0 || !req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    always begin
        @(posedge clk);
        #1;
        if (rr_rand) resp_ready = ($urandom_range(0, 3) != 0);
    end

    bit          prev_v  = 1'b0;
    bit          prev_hs = 1'b0;
    logic [31:0] prev_d  = '0;
    logic        prev_e  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_v  = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (resp_valid) begin
                if (!prev_v || prev_hs) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp: rdata 0x%08h with no request outstanding",
                                 resp_rdata);
                    end else begin
                        check("resp_latency", 32'(cyc - q[0].t), 32'(LAT + 1));
                    end
                end else begin
                    check("resp_rdata_stable", resp_rdata, prev_d);
                    check("resp_err_stable", 32'(resp_err), 32'(prev_e));
                end
                check("req_ready_in_resp", 32'(req_ready), 32'h0);
                if (resp_ready) begin
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        check("resp_rdata", resp_rdata, e.rdata);
                        check("resp_err", 32'(resp_err), 32'(e.err));
                    end
                    last_hs = cyc;
                end
            end
            prev_v  = resp_valid;
            prev_hs = resp_valid && resp_ready;
            prev_d  = resp_rdata;
            prev_e  = resp_err;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          t;
        int          t2;
        int          n;
        bit          w;
        logic [31:0] a;
        int          zacc;
        int          zresp;
        int          zlast;
        int          zpend;
        logic [31:0] zexp;

        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_z_req_ready", 32'(z_req_ready), 32'h1);
        check("rst_z_resp_valid", 32'(z_resp_valid), 32'h0);
        rst = 1'b0;
        resp_ready = 1'b1;

        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, t);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, t);
        wait_idle();

        do_req(1'b1, 32'h20, 32'h11223344, 4'hF, t);
        do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, t);
        do_req(1'b0, 32'h20, 32'h0, 4'h0, t);
        do_req(1'b1, 32'h24, 32'h99887766, 4'b0000, t);
        do_req(1'b0, 32'h24, 32'h0, 4'h0, t);
        wait_idle();

        do_req(1'b0, 32'h13, 32'h0, 4'h0, t);
        do_req(1'b1, 32'h1 << (AW + 2), 32'h5A5A5A5A, 4'hF, t);
        do_req(1'b0, 32'h0, 32'h0, 4'h0, t);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, t);
        wait_idle();

        // Response held off for five cycles while a second request waits.
        resp_ready = 1'b0;
        do_req(1'b0, 32'h20, 32'h0, 4'h0, t);
        fork
            do_req(1'b1, 32'h28, 32'h0BADF00D, 4'hF, t2);
            begin
                n = 0;
                while (!resp_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                repeat (5) begin
                    @(negedge clk);
                    check("held_req_ready", 32'(req_ready), 32'h0);
                    check("held_resp_valid", 32'(resp_valid), 32'h1);
                end
                @(posedge clk);
                #1;
                resp_ready = 1'b1;
            end
        join
        check("second_accept_cycle", 32'(t2), 32'(last_hs + 1));
        wait_idle();

        // Reset while a store is still waiting.
        do_req(1'b1, 32'h30, 32'h12345678, 4'hF, t);
        #2;
        rst = 1'b1;
        #1;
        check("wait_rst_req_ready", 32'(req_ready), 32'h1);
        check("wait_rst_resp_valid", 32'(resp_valid), 32'h0);
        check("wait_rst_resp_rdata", resp_rdata, 32'h0);
        check("wait_rst_resp_err", 32'(resp_err), 32'h0);
        q.delete();
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("post_rst_no_resp", 32'(resp_valid), 32'h0);
        end
        do_req(1'b0, 32'h30, 32'h0, 4'h0, t);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, t);
        wait_idle();

        rr_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15)) << 2;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) a = a | (32'h1 << (AW + 2 + $urandom_range(0, 19)));
            do_req(w, a, $urandom, 4'($urandom), t);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        wait_idle();
        rr_rand = 1'b0;
        @(posedge clk);
        #2;
        resp_ready = 1'b1;
        wait_idle();

        // Zero-latency instance: store then back-to-back loads.
        z_resp_ready = 1'b1;
        z_req_valid  = 1'b1;
        z_req_write  = 1'b1;
        z_req_addr   = 32'h44;
        z_req_wdata  = 32'hCAFEF00D;
        z_req_be     = 4'hF;
        zacc  = 0;
        zresp = 0;
        zlast = -1;
        zpend = -1;
        zexp  = '0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (z_resp_valid) begin
                zresp++;
                check("lat0_resp_time", 32'(cyc), 32'(zpend + 1));
                check("lat0_rdata", z_resp_rdata, zexp);
            end
            if (z_req_valid && z_req_ready) begin
                if (zlast >= 0) check("lat0_spacing", 32'(cyc - zlast), 32'h2);
                zlast = cyc;
                zpend = cyc;
                zexp  = z_req_write ? 32'h0 : 32'hCAFEF00D;
                zacc++;
                @(posedge clk);
                #1;
                z_req_write = 1'b0;
            end
        end
        z_req_valid = 1'b0;
        check("lat0_accepts", 32'(zacc), 32'h7);
        check("lat0_responses", 32'(zresp), 32'h7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the processor's data-memory port. It accepts one load or store request at a time from the memory stage over a valid/ready handshake. It performs the access into an internal word array after a programmable number of wait cycles and returns a held response. The CPU stalls on `req_ready`/`resp_valid` instead of assuming single-cycle memory.

## Interface
- `ADDR_WIDTH`, default 10: word-index width; array depth is 2^ADDR_WIDTH 32-bit words.
- `LATENCY`, default 2: wait cycles between request acceptance and array access; legal range 0..15.
- `clk` in 1: single clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `req_be` in 4: store byte enables; bit i enables byte i (bits 8i+7:8i). Ignored for loads.
- `resp_valid` out 1: response present.
- `resp_ready` in 1: CPU accepts the response.
- `resp_rdata` out 32: load data; 0 for stores.
- `resp_err` out 1: access faulted (see Configuration).

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, capture write, address, wdata and be into request registers.
  - Go to WAIT with the counter at LATENCY-1, or to RESP directly if LATENCY=0.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0, perform the access on that edge and go to RESP.
- RESP:
  - `resp_valid`=1.
  - `resp_rdata` and `resp_err` stay stable until the handshake.
  - On `resp_ready`, go to IDLE.
- `req_ready` is 1 only in IDLE. Requests are never accepted in WAIT or RESP.
- Access rules:
  - Word index = `req_addr[ADDR_WIDTH+1:2]`.
  - A store writes only the enabled bytes. A store with be=0 is a legal no-op that still returns a response.
  - A load returns the full word and captures it into the response register.
- Array contents and request registers clear to 0 on reset.

## Timing
- Values at reset: state IDLE; `req_ready`=1; `resp_valid`=0; `resp_rdata`=0; `resp_err`=0.
- Request handshake in cycle T. `resp_valid` rises at edge T+LATENCY+1, so the first cycle with a valid response is T+LATENCY+1.
- Minimum spacing between accepted requests is LATENCY+2 cycles when `resp_ready` is held high.
- A load at T+k observes every store whose response completed before T. Requests are strictly serialized, so there is no read/write overlap.
- `resp_ready` asserted outside RESP is ignored.
- `req_valid` dropping after acceptance has no effect.
- Reset asserted in WAIT or RESP:
  - Immediate return to IDLE and the array clears.
  - A store that is pending but not yet performed is discarded.
  - No response is produced after reset deasserts.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - A fault is `req_addr[1:0]`≠0, or any bit of `req_addr[31:ADDR_WIDTH+2]` set.
  - A faulting request still follows the full FSM timing.
  - A faulting store writes nothing. A faulting load returns `resp_rdata`=0.
  - `resp_err`=1 in RESP.
- Not defined:
  - Low two address bits and upper bits are ignored, so the address wraps modulo the array size.
  - `resp_err` is tied to 0.

## Structure
- Shared package holds:
  - FSM state encoding constants (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Default LATENCY and ADDR_WIDTH.
  - Response-error code constants.
- One sub-module, `dmem_array`:
  - Word-addressed synchronous array.
  - Byte-enable write port and registered read port.
  - Async clear on `rst`.
- `dmem_responder` holds the FSM, counter, request registers, fault check and response registers.

## Test plan
- Reset, then store addr 0x10, wdata 0xDEADBEEF, be=4'hF; then load 0x10. Required: load response 0xDEADBEEF, `resp_err`=0, `resp_valid` 3 cycles after each handshake with LATENCY=2.
- Store 0x11223344 to 0x20, then store 0xAABBCCDD with be=4'b0101. Required: load of 0x20 returns 0x11BB33DD.
- Hold `resp_ready`=0 for 5 cycles in RESP with `req_valid` high throughout. Required: `resp_rdata` stable, `req_ready`=0, and the second request is accepted only in the cycle after the handshake.
- With `DMEM_ALIGN_CHECK_EN`, load 0x13 and store to 2^(ADDR_WIDTH+2). Required: `resp_err`=1, `resp_rdata`=0, array unchanged. Without the macro, load 0x13 returns the word at 0x10.
- Accept a store, then assert `rst` during WAIT. Required: outputs return to reset values asynchronously, no `resp_valid` follows, and a subsequent load of that address returns 0.
- Run with LATENCY=0: a load handshake at T gives `resp_valid` at T+1; back-to-back loads with `resp_ready`=1 are accepted every 2 cycles.
